// File: rtl/irq_pending_arbiter.sv
// Edge-captured interrupt pending register with lowest-index selection,
// a valid/ready presentation port and a saturating coalesced-event counter.
module irq_pending_arbiter #(
    parameter int N  = 8,
    parameter int PW = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pos,
    output logic [N-1:0]  pending,
    output logic          drop_pulse,
    output logic [CW-1:0] drop_count
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  req_q, rise, clr, drop_vec, eligible, pending_nx;
    logic [PW-1:0] sel, pos_nx;
    logic [PW:0]   drop_num;
    logic [CW:0]   cnt_sum;
    logic [CW-1:0] count_nx;
    logic          valid_nx, hs;

    // Datapath: edge detect, retire, coalescing and lowest-index pick.
    always_comb begin
        rise       = req & ~req_q;
        hs         = out_valid & out_ready;
        clr        = '0;
        if (hs) clr[out_pos] = 1'b1;
        // A rise on the bit being retired survives: set wins over clear.
        pending_nx = (pending & ~clr) | rise;
        drop_vec   = rise & pending & ~clr;
        eligible   = pending & ~mask;
        sel        = '0;
        for (int i = N - 1; i >= 0; i--)
            if (eligible[i]) sel = PW'(i);
        drop_num   = '0;
        for (int i = 0; i < N; i++)
            drop_num = drop_num + (PW + 1)'(drop_vec[i]);
        cnt_sum    = {1'b0, drop_count} + (CW + 1)'(drop_num);
        count_nx   = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    end

    always_comb begin
        state_nx = state;
        valid_nx = out_valid;
        pos_nx   = out_pos;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nx = PRESENT;
                    valid_nx = 1'b1;
                    pos_nx   = sel;
                end
            end
            PRESENT: begin
                // Position stays frozen until accepted, regardless of mask.
                if (out_ready) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            pending    <= '0;
            out_valid  <= 1'b0;
            out_pos    <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_nx;
            req_q      <= req;
            pending    <= pending_nx;
            out_valid  <= valid_nx;
            out_pos    <= pos_nx;
            drop_pulse <= |drop_vec;
            drop_count <= count_nx;
        end
    end

endmodule
